// File: rtl/wb_arbiter_rr_nx1.sv
// Round-robin Wishbone bus-ownership arbiter, N masters onto one slave port.
// Define WB_ARB_TIMEOUT_EN to enable the slave watchdog (to_err_o / stb_block_o).
module wb_arbiter_rr_nx1 #(
    parameter int N_MASTERS      = 3,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ID_W           = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] cyc_i,
    input  logic [N_MASTERS-1:0] stb_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 gnt_valid_o,
    output logic [N_MASTERS-1:0] to_err_o,
    output logic                 stb_block_o
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
    logic                   gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic                   sel_found;
    logic [ID_W-1:0]        sel_id;
    logic [ID_W:0]          cand_sum;
    logic [ID_W-1:0]        cand;
    logic                   owner_cyc;
    logic [ID_W-1:0]        ptr_after_owner;

    assign owner_cyc = cyc_i[gnt_id_q];
    assign ptr_after_owner = (gnt_id_q == ID_W'(N_MASTERS - 1)) ? '0 : gnt_id_q + 1'b1;

    // Search upward from rr_ptr, wrapping at N_MASTERS-1; first requester wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (cand_sum >= (ID_W + 1)'(N_MASTERS)) begin
                cand_sum = cand_sum - (ID_W + 1)'(N_MASTERS);
            end
            cand = cand_sum[ID_W-1:0];
            if (!sel_found && cyc_i[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = OWNED;
            OWNED:   if (!owner_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt_d         = '0;
                    gnt_d[sel_id] = 1'b1;
                    gnt_id_d      = sel_id;
                    gnt_valid_d   = 1'b1;
                end
            end
            OWNED: begin
                if (!owner_cyc) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    rr_ptr_d    = ptr_after_owner;
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = gnt_valid_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic [N_MASTERS-1:0] to_err_q, to_err_d;
    logic                 stb_block_q, stb_block_d;
    logic                 unterminated;

    // Release, ACK and ERR all take priority over the timeout pulse.
    assign unterminated = (state_q == OWNED) && owner_cyc && stb_i[gnt_id_q]
                          && !s_ack_i && !s_err_i;

    always_comb begin
        wd_cnt_d    = '0;
        to_err_d    = '0;
        stb_block_d = 1'b0;
        if (unterminated) begin
            if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                to_err_d[gnt_id_q] = 1'b1;
                stb_block_d        = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt_q    <= '0;
            to_err_q    <= '0;
            stb_block_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            to_err_q    <= to_err_d;
            stb_block_q <= stb_block_d;
        end
    end

    assign to_err_o    = to_err_q;
    assign stb_block_o = stb_block_q;
`else
    logic unused_wd_inputs;
    assign unused_wd_inputs = ^{stb_i, s_ack_i, s_err_i, 16'(TIMEOUT_CYCLES)};

    assign to_err_o    = '0;
    assign stb_block_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr_nx1.sv
// Directed self-checking bench for wb_arbiter_rr_nx1 (3-master and 1-master builds).
module tb_wb_arbiter_rr_nx1;

`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [2:0] cyc, stb;
    logic       ack, err;
    logic [2:0] gnt, to_err;
    logic [1:0] gid;
    logic       gv, sblk;

    logic cyc1, stb1;
    logic gnt1, gid1, gv1, to1, sblk1;

    int checks = 0;
    int errors = 0;

    wb_arbiter_rr_nx1 #(.N_MASTERS(3), .TIMEOUT_CYCLES(8)) u_dut3 (
        .clk(clk), .rstn(rstn), .cyc_i(cyc), .stb_i(stb),
        .s_ack_i(ack), .s_err_i(err),
        .gnt_o(gnt), .gnt_id_o(gid), .gnt_valid_o(gv),
        .to_err_o(to_err), .stb_block_o(sblk)
    );

    wb_arbiter_rr_nx1 #(.N_MASTERS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .cyc_i(cyc1), .stb_i(stb1),
        .s_ack_i(1'b0), .s_err_i(1'b0),
        .gnt_o(gnt1), .gnt_id_o(gid1), .gnt_valid_o(gv1),
        .to_err_o(to1), .stb_block_o(sblk1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] eg, input logic [1:0] eid,
                           input logic ev);
        chk({tag, ".gnt"},   32'(gnt), 32'(eg));
        chk({tag, ".gid"},   32'(gid), 32'(eid));
        chk({tag, ".valid"}, 32'(gv),  32'(ev));
    endtask

    initial begin
        int exp_ids [5];
        logic [2:0] oh;
        logic [2:0] exp_to;
        exp_ids = '{1, 2, 0, 1, 2};
        exp_to  = TO_EN ? 3'b001 : 3'b000;

        rstn = 1'b0; cyc = '0; stb = '0; ack = 1'b0; err = 1'b0;
        cyc1 = 1'b0; stb1 = 1'b0;
        #12;
        chk_bus("reset", 3'b000, 2'd0, 1'b0);
        chk("reset.to_err", 32'(to_err), 32'd0);
        chk("reset.sblk",   32'(sblk),   32'd0);
        chk("reset1.gnt",   32'(gnt1),   32'd0);
        chk("reset1.valid", 32'(gv1),    32'd0);
        rstn = 1'b1;
        step();

        // single master 0 request, then release
        cyc = 3'b001;
        step();
        chk_bus("t1.grant", 3'b001, 2'd0, 1'b1);
        cyc = 3'b000;
        step();
        chk_bus("t1.release", 3'b000, 2'd0, 1'b0);

        // all masters requesting, each releases after 4 cycles then re-requests
        cyc = 3'b111;
        for (int k = 0; k < 5; k++) begin
            oh = 3'b001 << exp_ids[k];
            step();
            chk_bus("t2.grant", oh, 2'(exp_ids[k]), 1'b1);
            for (int h = 0; h < 3; h++) begin
                step();
                chk("t2.hold", 32'(gid), 32'(exp_ids[k]));
            end
            cyc[exp_ids[k]] = 1'b0;
            step();
            chk_bus("t2.dead", 3'b000, 2'(exp_ids[k]), 1'b0);
            cyc = 3'b111;
        end

        // no preemption: master 1 owns while 0 and 2 request
        cyc = 3'b010;
        step();
        chk_bus("t3.grant1", 3'b010, 2'd1, 1'b1);
        cyc = 3'b111;
        for (int h = 0; h < 3; h++) begin
            step();
            chk_bus("t3.hold", 3'b010, 2'd1, 1'b1);
        end
        cyc = 3'b101;
        step();
        chk_bus("t3.dead", 3'b000, 2'd1, 1'b0);
        step();
        chk_bus("t3.grant2", 3'b100, 2'd2, 1'b1);

        // watchdog on owner 0
        cyc = 3'b001;
        step();
        chk("t4.rel2", 32'(gv), 32'd0);
        step();
        chk_bus("t4.grant0", 3'b001, 2'd0, 1'b1);
        stb = 3'b001;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4.nopulse", 32'(to_err), 32'd0);
        end
        step();
        chk("t4.pulse",      32'(to_err), 32'(exp_to));
        chk("t4.pulse.sblk", 32'(sblk),   32'(TO_EN));
        chk_bus("t4.retain", 3'b001, 2'd0, 1'b1);
        step();
        chk("t4.oneshot",      32'(to_err), 32'd0);
        chk("t4.oneshot.sblk", 32'(sblk),   32'd0);

        stb = 3'b000;
        step();
        stb = 3'b001;
        repeat (7) step();
        ack = 1'b1;
        step();
        chk("t4.ackwins", 32'(to_err), 32'd0);
        ack = 1'b0;
        step();
        chk("t4.ackclr", 32'(to_err), 32'd0);

        stb = 3'b000;
        step();
        stb = 3'b001;
        repeat (7) step();
        cyc = 3'b000;
        step();
        chk("t4.relwins", 32'(to_err), 32'd0);
        chk("t4.relwins.valid", 32'(gv), 32'd0);
        stb = 3'b000;

        // asynchronous reset mid-tenure, then fresh search from pointer 0
        cyc = 3'b100;
        step();
        chk_bus("t5.grant2", 3'b100, 2'd2, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk_bus("t5.async", 3'b000, 2'd0, 1'b0);
        chk("t5.async.to_err", 32'(to_err), 32'd0);
        chk("t5.async.sblk",   32'(sblk),   32'd0);
        #3 rstn = 1'b1;
        step();
        chk_bus("t5.regrant", 3'b100, 2'd2, 1'b1);
        cyc = 3'b000;
        step();

        // single-master build: repeated CYC pulses
        for (int p = 0; p < 3; p++) begin
            cyc1 = 1'b1;
            step();
            chk("t6.gnt",   32'(gnt1), 32'd1);
            chk("t6.gid",   32'(gid1), 32'd0);
            chk("t6.valid", 32'(gv1),  32'd1);
            cyc1 = 1'b0;
            step();
            chk("t6.dead.gnt",   32'(gnt1), 32'd0);
            chk("t6.dead.gid",   32'(gid1), 32'd0);
            chk("t6.dead.valid", 32'(gv1),  32'd0);
        end
        chk("t6.to_err", 32'(to1),   32'd0);
        chk("t6.sblk",   32'(sblk1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
